// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared types for the writeback arbiter and scoreboard
package wb_arbiter_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam int NUM_REGS = 32;

  // Which producer owns the value sitting in the output register
  typedef enum logic {
    WB_EXE = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - pending long-latency write tracker with two query ports
module wb_scoreboard
  import wb_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     set_valid,
  input  reg_idx_t set_idx,
  input  logic     clr_valid,
  input  reg_idx_t clr_idx,
  input  reg_idx_t rs1,
  input  reg_idx_t rs2,
  output logic     rs1_busy,
  output logic     rs2_busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Next busy vector: clear first so a same-edge set of that index wins; x0 never busy
  always_comb begin
    busy_d = busy_q;
    if (clr_valid) begin
      busy_d[clr_idx] = 1'b0;
    end
    if (set_valid && (set_idx != '0)) begin
      busy_d[set_idx] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy vector register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Query ports read the current bits directly; a same-cycle clear is not bypassed
  assign rs1_busy = (rs1 != '0) && busy_q[rs1];
  assign rs2_busy = (rs2 != '0) && busy_q[rs2];

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - exe/lsu writeback arbiter with starvation guard and registered write port
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             exe_valid,
  output logic             exe_ready,
  input  logic [4:0]       exe_rd,
  input  logic [WIDTH-1:0] exe_data,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [4:0]       lsu_rd,
  input  logic [WIDTH-1:0] lsu_data,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic [4:0]       rd,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_we
);

  localparam int            CW         = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0]    starve_cnt_q, starve_cnt_d;
  reg_idx_t         rd_q, rd_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_we_q, rd_we_d;
  wb_src_e          src_q, src_d;

  logic force_lsu;
  logic exe_fire;
  logic lsu_fire;

  // Ready depends only on exe_valid and the registered counter, never on data
  assign force_lsu = (starve_cnt_q == STARVE_LIM);
  assign exe_ready = !force_lsu;
  assign lsu_ready = force_lsu || !exe_valid;
  assign exe_fire  = exe_valid && exe_ready;
  assign lsu_fire  = lsu_valid && lsu_ready;

  // Count consecutive lsu denials; any lsu win or idle lsu restarts the count
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!lsu_valid || lsu_fire) begin
      starve_cnt_d = '0;
    end else if (exe_valid && !lsu_ready && (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end
  end

  // Output register reloads every cycle; fires are mutually exclusive by construction
  always_comb begin
    rd_d      = rd_q;
    rd_data_d = rd_data_q;
    src_d     = src_q;
    rd_we_d   = 1'b0;
    if (exe_fire) begin
      rd_d      = exe_rd;
      rd_data_d = exe_data;
      rd_we_d   = (exe_rd != '0);
      src_d     = WB_EXE;
    end else if (lsu_fire) begin
      rd_d      = lsu_rd;
      rd_data_d = lsu_data;
      rd_we_d   = (lsu_rd != '0);
      src_d     = WB_LSU;
    end
  end

  // Arbiter state and write-port register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      rd_q         <= '0;
      rd_data_q    <= '0;
      rd_we_q      <= 1'b0;
      src_q        <= WB_EXE;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_q         <= rd_d;
      rd_data_q    <= rd_data_d;
      rd_we_q      <= rd_we_d;
      src_q        <= src_d;
    end
  end

  assign rd      = rd_q;
  assign rd_data = rd_data_q;
  assign rd_we   = rd_we_q;

  // Pending-load tracker; a load's busy bit clears on the edge the register file stores it
  wb_scoreboard u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_valid (issue_valid),
    .set_idx   (issue_rd),
    .clr_valid (rd_we_q && (src_q == WB_LSU)),
    .clr_idx   (rd_q),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy)
  );

endmodule
